// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates N_CH requestor channels onto the byte-serial RAM/UART bus.
// An access of 1, 2 or 4 bytes is serialised little-endian. Writes to the UART window
// (addr[17:16] == 2'b11) wait while io_buffer_full is set. A read marked flushable is
// abandoned when flush arrives.
//
// Ports
//   clk_in, rst_in    clock, synchronous active-high reset
//   rdy_in            0 = hold all state and force mem_wr low
//   flush             mispredict flush; cancels flushable reads
//   req_*             per-channel request bundle; req_en is held until resp_rdy
//   resp_rdy          one-cycle completion pulse per channel
//   resp_data         zero-extended read data, valid with resp_rdy
//   mem_din/mem_dout  RAM read byte (1-cycle latency) and write byte
//   mem_a, mem_wr     RAM address and write strobe
//   io_buffer_full    UART transmit buffer full
//
// Configuration: define MEM_ARB_RR_EN for round-robin arbitration. By default
// arbitration is fixed priority, and channel 0 has the highest priority.
module mem_arbiter #(
  parameter int N_CH = 3,
  parameter int CH_W = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 flush,
  input  logic [N_CH-1:0]      req_en,
  input  logic [N_CH-1:0]      req_wr,
  input  logic [2*N_CH-1:0]    req_size,
  input  logic [32*N_CH-1:0]   req_addr,
  input  logic [32*N_CH-1:0]   req_wdata,
  input  logic [N_CH-1:0]      req_flushable,
  output logic [N_CH-1:0]      resp_rdy,
  output logic [31:0]          resp_data,
  input  logic [7:0]           mem_din,
  output logic [7:0]           mem_dout,
  output logic [31:0]          mem_a,
  output logic                 mem_wr,
  input  logic                 io_buffer_full
);

  typedef enum logic [2:0] {IDLE, READ, WRITE, IOWAIT, DONE} state_t;

  state_t            state_q;
  logic [CH_W-1:0]   ch_q;
  logic [31:0]       addr_q, wdata_q;
  logic [2:0]        n_q;
  logic [2:0]        cnt_q;     // READ: cycle index within the access; WRITE/IOWAIT: next byte
  logic              fl_q;
  logic [N_CH-1:0]   excl_q;    // channels that pulsed resp_rdy last cycle
  logic [N_CH-1:0]   resp_rdy_q;
  logic [31:0]       resp_data_q, mem_a_q;
  logic [7:0]        mem_dout_q;
  logic              mem_wr_q;

  logic [N_CH-1:0]   elig;
  logic              gnt_vld;
  logic [CH_W-1:0]   gnt_idx;
  logic              sel_wr, sel_fl;
  logic [1:0]        sel_size;
  logic [2:0]        sel_n;
  logic [31:0]       sel_addr, sel_wdata;
  logic [1:0]        cap_idx;
  logic              io_q;

  // A flushable read cannot be granted in a cycle that carries a flush.
  assign elig = req_en & ~excl_q & ~({N_CH{flush}} & ~req_wr & req_flushable);

`ifdef MEM_ARB_RR_EN
  logic [CH_W-1:0] rr_q;

  always_comb begin : arb
    int j;
    j       = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    // The search starts at rr_q and wraps at N_CH.
    for (int k = 0; k < N_CH; k++) begin
      j = int'(rr_q) + k;
      if (j >= N_CH) j = j - N_CH;
      if (!gnt_vld && elig[j]) begin
        gnt_vld = 1'b1;
        gnt_idx = CH_W'(j);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in)
      rr_q <= '0;
    else if (rdy_in && state_q == IDLE && gnt_vld)
      rr_q <= (gnt_idx == CH_W'(N_CH-1)) ? '0 : gnt_idx + 1'b1;
  end
`else
  always_comb begin : arb
    gnt_vld = 1'b0;
    gnt_idx = '0;
    // Scan from the top down, so the lowest eligible index is written last and wins.
    for (int k = N_CH-1; k >= 0; k--) begin
      if (elig[k]) begin
        gnt_vld = 1'b1;
        gnt_idx = CH_W'(k);
      end
    end
  end
`endif

  always_comb begin : sel
    sel_wr    = 1'b0;
    sel_fl    = 1'b0;
    sel_size  = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (gnt_idx == CH_W'(k)) begin
        sel_wr    = req_wr[k];
        sel_fl    = req_flushable[k];
        sel_size  = req_size[2*k +: 2];
        sel_addr  = req_addr[32*k +: 32];
        sel_wdata = req_wdata[32*k +: 32];
      end
    end
    case (sel_size)
      2'd0:    sel_n = 3'd1;
      2'd1:    sel_n = 3'd2;
      default: sel_n = 3'd4;
    endcase
  end

  // In READ, the byte captured at cycle index cnt_q is byte (cnt_q - 2).
  assign cap_idx = cnt_q[1:0] - 2'd2;
  assign io_q    = (addr_q[17:16] == 2'b11);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      n_q         <= '0;
      cnt_q       <= '0;
      fl_q        <= 1'b0;
      excl_q      <= '0;
      resp_rdy_q  <= '0;
      resp_data_q <= '0;
      mem_a_q     <= '0;
      mem_dout_q  <= '0;
      mem_wr_q    <= 1'b0;
    end else if (rdy_in) begin
      // The bus is idle unless a state below drives a byte.
      excl_q     <= resp_rdy_q;
      resp_rdy_q <= '0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      mem_wr_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            ch_q    <= gnt_idx;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            n_q     <= sel_n;
            fl_q    <= sel_fl;
            if (!sel_wr) begin
              state_q     <= READ;
              mem_a_q     <= sel_addr;
              cnt_q       <= 3'd1;
              resp_data_q <= '0;
            end else if (sel_addr[17:16] == 2'b11 && io_buffer_full) begin
              state_q <= IOWAIT;
              cnt_q   <= 3'd0;
            end else begin
              state_q    <= WRITE;
              mem_a_q    <= sel_addr;
              mem_dout_q <= sel_wdata[7:0];
              mem_wr_q   <= 1'b1;
              cnt_q      <= 3'd1;
            end
          end
        end
        READ: begin
          if (flush && fl_q) begin
            state_q <= IDLE;
          end else begin
            if (cnt_q >= 3'd2) resp_data_q[8*cap_idx +: 8] <= mem_din;
            if (cnt_q < n_q)   mem_a_q <= addr_q + {29'b0, cnt_q};
            if (cnt_q == n_q + 3'd1) begin
              state_q    <= DONE;
              resp_rdy_q <= N_CH'(1) << ch_q;
            end
            cnt_q <= cnt_q + 3'd1;
          end
        end
        WRITE: begin
          if (cnt_q == n_q) begin
            state_q    <= DONE;
            resp_rdy_q <= N_CH'(1) << ch_q;
          end else if (io_q && io_buffer_full) begin
            // The UART buffer state is checked again before every byte.
            state_q <= IOWAIT;
          end else begin
            mem_a_q    <= addr_q + {29'b0, cnt_q};
            mem_dout_q <= wdata_q[8*cnt_q[1:0] +: 8];
            mem_wr_q   <= 1'b1;
            cnt_q      <= cnt_q + 3'd1;
          end
        end
        IOWAIT: begin
          if (!io_buffer_full) begin
            state_q    <= WRITE;
            mem_a_q    <= addr_q + {29'b0, cnt_q};
            mem_dout_q <= wdata_q[8*cnt_q[1:0] +: 8];
            mem_wr_q   <= 1'b1;
            cnt_q      <= cnt_q + 3'd1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign resp_rdy  = resp_rdy_q;
  assign resp_data = resp_data_q;
  assign mem_a     = mem_a_q;
  assign mem_dout  = mem_dout_q;
  assign mem_wr    = mem_wr_q & rdy_in;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter. It applies a table of single accesses, then runs hand-written
// sequences for IO stall, arbitration order, flush, rdy_in freeze and mid-access reset.
// Written bytes and responses are checked against a scoreboard.
module tb_mem_arbiter;
  localparam int N_CH = 3;
  localparam int CH_W = 2;

  logic                clk = 1'b0;
  logic                rst_in, rdy_in, flush, io_buffer_full;
  logic [N_CH-1:0]     req_en, req_wr, req_flushable;
  logic [2*N_CH-1:0]   req_size;
  logic [32*N_CH-1:0]  req_addr, req_wdata;
  logic [N_CH-1:0]     resp_rdy;
  logic [31:0]         resp_data, mem_a;
  logic [7:0]          mem_din = 8'h00;
  logic [7:0]          mem_dout;
  logic                mem_wr;

  mem_arbiter #(.N_CH(N_CH), .CH_W(CH_W)) dut (
    .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .req_en(req_en), .req_wr(req_wr), .req_size(req_size), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_flushable(req_flushable),
    .resp_rdy(resp_rdy), .resp_data(resp_data),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  // RAM model: ram[i] = i[7:0], except 0x100..0x103 = 11 22 33 44. Reads have one
  // cycle of latency. The RAM pauses together with the rest of the system while rdy_in is low.
  logic [7:0] ram [0:1023];
  always @(posedge clk) if (rdy_in) mem_din <= ram[mem_a[9:0]];

  typedef struct { logic [31:0] addr; logic [7:0] data; } wexp_t;
  typedef struct { int ch; bit rd; logic [31:0] data; } rexp_t;
  typedef struct {
    int ch; bit wr; logic [1:0] size; logic [31:0] addr; logic [31:0] wdata;
    bit fl; logic [31:0] exp_data; int exp_lat;
  } vec_t;

  wexp_t wq[$];
  rexp_t rq[$];
  int    n_chk = 0, n_fail = 0;
  bit    mon_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every written byte and every response is popped from the scoreboard.
  always @(negedge clk) if (mon_en) begin
    if (!rdy_in) check("mem_wr_frozen", {31'b0, mem_wr}, 32'd0);
    if (mem_wr) begin
      if (wq.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_write: a=%h d=%h at %0t", mem_a, mem_dout, $time);
      end else begin
        wexp_t w;
        w = wq.pop_front();
        check("wr_addr", mem_a, w.addr);
        check("wr_byte", {24'b0, mem_dout}, {24'b0, w.data});
      end
    end
    if (resp_rdy != '0) begin
      if (rq.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_resp: resp_rdy=%b at %0t", resp_rdy, $time);
      end else begin
        rexp_t r;
        r = rq.pop_front();
        check("resp_ch", {29'b0, resp_rdy}, 32'd1 << r.ch);
        if (r.rd) check("resp_data", resp_data, r.data);
      end
    end
  end

  task automatic drive_req(input int ch, input bit wr, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] wd, input bit fl);
    req_wr[ch]             = wr;
    req_size[2*ch +: 2]    = sz;
    req_addr[32*ch +: 32]  = a;
    req_wdata[32*ch +: 32] = wd;
    req_flushable[ch]      = fl;
    req_en[ch]             = 1'b1;
  endtask

  task automatic push_exp(input int ch, input bit wr, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd);
    int    n;
    wexp_t w;
    rexp_t r;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    if (wr) for (int i = 0; i < n; i++) begin
      w.addr = a + i;
      w.data = wd[8*i +: 8];
      wq.push_back(w);
    end
    r.ch = ch; r.rd = !wr; r.data = rd;
    rq.push_back(r);
  endtask

  task automatic issue(input int ch, input bit wr, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd, input bit fl,
                       input logic [31:0] rd);
    push_exp(ch, wr, sz, a, wd, rd);
    drive_req(ch, wr, sz, a, wd, fl);
  endtask

  // Waits for resp_rdy[ch] with a cycle budget. lat is counted from the cycle after the call,
  // and the requester drops req_en right after it sees the pulse.
  task automatic wait_resp(input int ch, input int budget, output int lat);
    lat = -1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (resp_rdy[ch]) begin lat = c; break; end
    end
    @(posedge clk); #1;
    req_en[ch] = 1'b0;
  endtask

  task automatic gap();
    @(posedge clk); #1;
  endtask

  // Sequence with an optional rdy_in low window, a one-cycle reset at rst_cyc, and
  // io_buffer_full held through cycle io_to.
  task automatic run_seq(input string nm, input int ch, input int exp_lat, input int rlo_from,
                         input int rlo_to, input int rst_cyc, input int io_to);
    int lat;
    lat = -1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c == rst_cyc + 1) begin
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_mem_wr", {31'b0, mem_wr}, 32'd0);
        check("rst_mem_dout", {24'b0, mem_dout}, 32'd0);
        check("rst_resp_rdy", {29'b0, resp_rdy}, 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
      end
      if (c <= io_to + 1) check("iowait_no_wr", {31'b0, mem_wr}, 32'd0);
      if (resp_rdy[ch] && lat < 0) lat = c;
      @(posedge clk); #1;
      rdy_in         = !((c + 1) >= rlo_from && (c + 1) <= rlo_to);
      rst_in         = (c + 1 == rst_cyc);
      io_buffer_full = (c + 1 <= io_to);
      if (lat >= 0) begin req_en[ch] = 1'b0; break; end
    end
    rdy_in = 1'b1; rst_in = 1'b0; io_buffer_full = 1'b0;
    check(nm, lat, exp_lat);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[9];
    int   lat, first, second;
    wexp_t w;

    for (int i = 0; i < 1024; i++) ram[i] = i[7:0];
    ram[256] = 8'h11; ram[257] = 8'h22; ram[258] = 8'h33; ram[259] = 8'h44;

    vt[0] = '{1, 0, 2'd2, 32'h0000_0100, 32'h0, 0, 32'h4433_2211, 6};
    vt[1] = '{0, 0, 2'd0, 32'h0000_0105, 32'h0, 0, 32'h0000_0005, 3};
    vt[2] = '{2, 0, 2'd1, 32'h0000_03FE, 32'h0, 0, 32'h0000_FFFE, 4};
    vt[3] = '{0, 0, 2'd3, 32'h0000_0040, 32'h0, 0, 32'h4342_4140, 6};
    vt[4] = '{1, 0, 2'd2, 32'hFFFF_FFFE, 32'h0, 0, 32'h0100_FFFE, 6};
    vt[5] = '{2, 1, 2'd2, 32'h0000_1000, 32'hDEAD_BEEF, 0, 32'h0, 5};
    vt[6] = '{1, 1, 2'd0, 32'hFFFF_FFFF, 32'h0000_0077, 0, 32'h0, 2};
    vt[7] = '{0, 1, 2'd1, 32'hFFFF_FFFF, 32'h0000_CAFE, 0, 32'h0, 3};
    vt[8] = '{0, 0, 2'd0, 32'h0000_0002, 32'h0, 1, 32'h0000_0002, 3};

    rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
    req_en = '0; req_wr = '0; req_flushable = '0; req_size = '0;
    req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_resp_rdy", {29'b0, resp_rdy}, 32'd0);
    check("reset_resp_data", resp_data, 32'd0);
    check("reset_mem_a", mem_a, 32'd0);
    check("reset_mem_dout", {24'b0, mem_dout}, 32'd0);
    check("reset_mem_wr", {31'b0, mem_wr}, 32'd0);
    @(posedge clk); #1;
    rst_in = 1'b0;
    mon_en = 1'b1;
    gap();

    // Table of single accesses: sizes, wrap-around, UART write without a stall, size code 3.
    for (int v = 0; v < 9; v++) begin
      issue(vt[v].ch, vt[v].wr, vt[v].size, vt[v].addr, vt[v].wdata, vt[v].fl, vt[v].exp_data);
      wait_resp(vt[v].ch, 20, lat);
      check($sformatf("vec%0d_latency", v), lat, vt[v].exp_lat);
      gap();
    end

    // ch1 4-byte read at 0x100: address per cycle, then req_en held one cycle past the pulse.
    issue(1, 0, 2'd2, 32'h100, 32'h0, 0, 32'h4433_2211);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("t1_mem_a_c%0d", c), mem_a,
            (c >= 1 && c <= 4) ? 32'h100 + c - 1 : 32'h0);
      check($sformatf("t1_resp_c%0d", c), {29'b0, resp_rdy}, (c == 6) ? 32'd2 : 32'd0);
      @(posedge clk); #1;
      if (c == 7) req_en[1] = 1'b0;
    end
    gap();

    // UART write that stalls on io_buffer_full for cycles 0-4.
    io_buffer_full = 1'b1;
    issue(0, 1, 2'd1, 32'h0003_0000, 32'h0000_BEEF, 0, 32'h0);
    run_seq("t2_io_latency", 0, 8, 100, 0, -100, 4);
    gap();

    // Arbitration order. ch0 goes alone first, which leaves the rr pointer at 1.
    issue(0, 0, 2'd0, 32'h10, 32'h0, 0, 32'h10);
    wait_resp(0, 20, lat);
    check("t3_solo_latency", lat, 3);
    gap();
`ifdef MEM_ARB_RR_EN
    first = 2; second = 0;
`else
    first = 0; second = 2;
`endif
    push_exp(first, 0, 2'd0, 32'h10 + first, 32'h0, 32'h10 + first);
    push_exp(second, 0, 2'd0, 32'h10 + second, 32'h0, 32'h10 + second);
    drive_req(0, 0, 2'd0, 32'h10, 32'h0, 0);
    drive_req(2, 0, 2'd0, 32'h12, 32'h0, 0);
    wait_resp(first, 20, lat);
    check("t3_first_latency", lat, 3);
    wait_resp(second, 20, lat);
    check("t3_second_latency", lat, 3);
    gap();

    // Flush in cycle 3 of a flushable 4-byte read: back to IDLE, no response.
    drive_req(1, 0, 2'd2, 32'h200, 32'h0, 1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 3) check("t4_mem_a_c3", mem_a, 32'h202);
      if (c >= 4) check($sformatf("t4_mem_a_c%0d", c), mem_a, 32'h0);
      check($sformatf("t4_no_resp_c%0d", c), {29'b0, resp_rdy}, 32'd0);
      @(posedge clk); #1;
      flush = (c + 1 == 3);
      if (c + 1 == 4) req_en[1] = 1'b0;
    end
    // A write and a non-flushable read both complete with flush held high.
    flush = 1'b1;
    issue(2, 1, 2'd1, 32'h1004, 32'h0000_A55A, 0, 32'h0);
    wait_resp(2, 20, lat);
    check("t4_write_under_flush", lat, 3);
    gap();
    issue(0, 0, 2'd2, 32'h200, 32'h0, 0, 32'h0302_0100);
    wait_resp(0, 20, lat);
    check("t4_nonflush_read", lat, 6);
    flush = 1'b0;
    gap();
    // A flush in IDLE blocks the grant of a flushable read for that cycle only.
    flush = 1'b1;
    issue(1, 0, 2'd0, 32'h31, 32'h0, 1, 32'h31);
    gap();
    flush = 1'b0;
    wait_resp(1, 20, lat);
    check("t4_idle_flush_delay", lat + 1, 4);
    gap();

    // rdy_in low in cycles 2-4 of a 1-byte read, and in cycle 1 of a 2-byte write.
    issue(0, 0, 2'd0, 32'h20, 32'h0, 0, 32'h20);
    run_seq("t5_read_freeze", 0, 6, 2, 4, -100, -1);
    gap();
    issue(1, 1, 2'd1, 32'h1010, 32'h0000_1234, 0, 32'h0);
    run_seq("t5_write_freeze", 1, 4, 1, 1, -100, -1);
    gap();

    // Reset in cycle 2 of a 4-byte write. The held request is granted again from the start.
    w.addr = 32'h1000; w.data = 8'h44; wq.push_back(w);
    w.addr = 32'h1001; w.data = 8'h33; wq.push_back(w);
    issue(2, 1, 2'd2, 32'h1000, 32'h1122_3344, 0, 32'h0);
    run_seq("t6_regrant_latency", 2, 8, 100, 0, 2, -1);
    gap(); gap();

    check("wq_drained", wq.size(), 32'd0);
    check("rq_drained", rq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
